aging_pattern_gen: RTL and testbench

//  Aging/burn-in video source producing the 27-bit display-port stream
//  {vsync,hsync,den,R[7:0],G[7:0],B[7:0]} consumed directly by the

---
 rtl/aging_pattern_gen.sv | 122 ++++++++++++
 tb/tb_aging_pattern_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/aging_pattern_gen.sv
// aging_pattern_gen: burn-in raster source cycling 8 test patterns onto a {vsync,hsync,den,RGB} stream
module aging_pattern_gen #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int FRAMES_PER_PAT = 60,
  parameter int CHK_SHIFT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_mode,
  input  logic [2:0]  pat_sel,
  output logic [26:0] DPo,
  output logic [2:0]  pat_idx,
  output logic        frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int FW  = $clog2(FRAMES_PER_PAT + 1);
  localparam int BW  = H_ACTIVE / 8;
  localparam int BCW = $clog2(BW + 1);
  localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS0    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS1    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS0    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS1    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FW-1:0]  F_LAST = FW'(FRAMES_PER_PAT - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BW - 1);

  logic [HW-1:0]  h_cnt, hc;
  logic [VW-1:0]  v_cnt, vc;
  logic [BCW-1:0] bar_px;
  logic [2:0]     bar, pat, pat_nxt;
  logic [FW-1:0]  fcnt, fcnt_nxt;
  logic           h_last, v_last, boundary, den, hs, vs;
  logic [7:0]     x8;
  logic [23:0]    rgb;

  assign h_last   = h_cnt == H_LAST;
  assign v_last   = v_cnt == V_LAST;
  assign boundary = en && h_last && v_last;

  // bar_px/bar track the colour-bar position alongside h_cnt so no divider is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      bar_px <= '0;
      bar    <= '0;
    end else if (!en) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      bar_px <= '0;
      bar    <= '0;
    end else begin
      h_cnt  <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      bar_px <= (h_last || bar_px == B_LAST) ? '0 : bar_px + 1'b1;
      bar    <= h_last ? '0 : bar + 3'(bar_px == B_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= '0;
      fcnt <= '0;
    end else begin
      pat  <= pat_nxt;
      fcnt <= fcnt_nxt;
    end
  end

  always_comb begin
    fcnt_nxt = (!auto_mode || (boundary && fcnt == F_LAST)) ? '0 : fcnt + FW'(boundary);
    pat_nxt  = !boundary ? pat : !auto_mode ? pat_sel : (fcnt == F_LAST) ? pat + 3'd1 : pat;
  end

  always_comb begin
    den = h_cnt < H_ACT && v_cnt < V_ACT;
    hs  = h_cnt >= HS0 && h_cnt < HS1;
    vs  = v_cnt >= VS0 && v_cnt < VS1;
    hc  = h_cnt >> CHK_SHIFT;
    vc  = v_cnt >> CHK_SHIFT;
    x8  = 8'(h_cnt);
    rgb = '0;
    case (pat)
      3'd1: rgb = 24'hFFFFFF;
      3'd2: rgb = 24'hFF0000;
      3'd3: rgb = 24'h00FF00;
      3'd4: rgb = 24'h0000FF;
      3'd5: rgb = {x8, x8, x8};
      3'd6: rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      3'd7: rgb = (hc[0] ^ vc[0]) ? 24'hFFFFFF : 24'h000000;
      default: rgb = '0;
    endcase
    if (!den) rgb = '0;
  end

  // pat_idx is registered with DPo so it names the pattern of the beat on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DPo       <= '0;
      pat_idx   <= '0;
      frame_end <= 1'b0;
    end else begin
      DPo       <= en ? {vs, hs, den, rgb} : '0;
      pat_idx   <= pat;
      frame_end <= boundary;
    end
  end
endmodule

// File: tb/tb_aging_pattern_gen.sv
// tb_aging_pattern_gen: scoreboard bench for aging_pattern_gen on a 24x12 raster
module tb_aging_pattern_gen;
  logic        clk = 0, rst = 1, en = 0, auto_mode = 0;
  logic [2:0]  pat_sel = 0;
  logic [26:0] DPo;
  logic [2:0]  pat_idx;
  logic        frame_end;
  int checks = 0, errors = 0;

  typedef struct packed {logic [26:0] dpo; logic [2:0] pat; logic fe;} exp_t;
  exp_t q[$];
  int mx = 0, my = 0, mfcnt = 0;
  logic [2:0] mpat = 0;

  always #5 clk = ~clk;

  aging_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FRAMES_PER_PAT(2), .CHK_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .auto_mode(auto_mode), .pat_sel(pat_sel),
    .DPo(DPo), .pat_idx(pat_idx), .frame_end(frame_end)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [26:0] pix(int x, int y, logic [2:0] p);
    logic [23:0] c;
    logic d;
    d = x < 16 && y < 8;
    c = 0;
    if (d)
      case (p)
        1: c = 24'hFFFFFF;
        2: c = 24'hFF0000;
        3: c = 24'h00FF00;
        4: c = 24'h0000FF;
        5: c = {x[7:0], x[7:0], x[7:0]};
        6: c = bar_rgb(x / 2);
        7: c = (((x / 4) + (y / 4)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
        default: c = 0;
      endcase
    return {y >= 9 && y < 11, x >= 18 && x < 21, d, c};
  endfunction

  // reference raster and pattern sequencer, one step per clock
  always @(posedge clk) begin
    exp_t e;
    bit bnd;
    if (rst) begin
      mx = 0; my = 0; mpat = 0; mfcnt = 0;
      q.push_back('0);
    end else begin
      bnd = en && mx == 23 && my == 11;
      e.dpo = en ? pix(mx, my, mpat) : '0;
      e.pat = mpat;
      e.fe  = bnd;
      q.push_back(e);
      if (!en) begin mx = 0; my = 0; end
      else if (mx == 23) begin mx = 0; my = (my == 11) ? 0 : my + 1; end
      else mx++;
      if (bnd) begin
        if (auto_mode) begin
          if (mfcnt == 1) begin mpat++; mfcnt = 0; end else mfcnt++;
        end else mpat = pat_sel;
      end
      if (!auto_mode) mfcnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dpo", 32'(DPo), 32'(e.dpo));
      chk("pat_idx", 32'(pat_idx), 32'(e.pat));
      chk("frame_end", 32'(frame_end), 32'(e.fe));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fe();
    int n = 0;
    while (!frame_end && n < 400) begin @(negedge clk); n++; end
    chk("fe_seen", 32'(frame_end), 1);
  endtask

  task automatic wait_pos(input int x, input int y);
    int n = 0;
    while (!(mx == x && my == y) && n < 400) begin @(negedge clk); n++; end
    chk("pos_reached", 32'(n < 400), 1);
  endtask

  task automatic frame_stats();
    int d = 0, h = 0, v = 0;
    for (int i = 0; i < 288; i++) begin
      @(negedge clk);
      d += int'(DPo[24]);
      h += int'(DPo[25]);
      v += int'(DPo[26]);
    end
    chk("den_cnt", 32'(d), 128);
    chk("hsync_cnt", 32'(h), 36);
    chk("vsync_cnt", 32'(v), 48);
    chk("fe_period", 32'(frame_end), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dpo", 32'(DPo), 0);
    chk("rst_pat", 32'(pat_idx), 0);
    chk("rst_fe", 32'(frame_end), 0);
    @(negedge clk) rst = 0;
    pat_sel = 2; en = 1;
    wait_fe();
    frame_stats();
    pat_sel = 6; run(600);
    pat_sel = 7; run(600);
    pat_sel = 5; run(600);
    pat_sel = 3; run(600);
    wait_pos(5, 2);
    pat_sel = 4; run(50);
    chk("pat_hold", 32'(pat_idx), 3);
    wait_fe();
    @(negedge clk);
    chk("pat_switch", 32'(pat_idx), 4);
    repeat (12) begin
      pat_sel = 3'($urandom_range(0, 7));
      run($urandom_range(50, 200));
    end
    rst = 1; auto_mode = 1;
    @(negedge clk) rst = 0;
    repeat (4608) @(negedge clk);
    chk("auto_last", 32'(pat_idx), 7);
    @(negedge clk);
    chk("auto_wrap", 32'(pat_idx), 0);
    run(200);
    wait_pos(7, 3);
    rst = 1; en = 0;
    @(negedge clk) rst = 0;
    run(5);
    chk("idle_dpo", 32'(DPo), 0);
    chk("idle_pat", 32'(pat_idx), 0);
    en = 1;
    @(negedge clk);
    chk("first_den", 32'(DPo[24]), 1);
    n = 1;
    while (!frame_end && n < 400) begin @(negedge clk); n++; end
    chk("fe_after_en", 32'(n), 288);
    run(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
